// File: rtl/crc32_arb.sv
// Round-robin arbiter sharing one crc32_core among NUM_REQ requesters, one message per grant.
// Latency: req at cycle t -> gnt_o at t+1; datapath mux and response routing are combinational.
// Backpressure: losers see no ack/done and wait on req_i; grant held from start until core done.
//
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   req_i/start_i/val_i/lst_i         per-requester control, one bit each
//   dat_i [32k+31:32k], num_i [2k+1:2k] per-requester beat data / valid-bytes-minus-1
//   gnt_o, gnt_id_o, busy_o           registered one-hot grant, its index (held when idle), GNT|RUN
//   ack_o, done_o, crc_o              core responses routed to the granted requester, crc broadcast
//   core_*_o / core_*_i               crc32_core side
module crc32_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_WD   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     start_i,
    input  logic [NUM_REQ-1:0]     val_i,
    input  logic [32*NUM_REQ-1:0]  dat_i,
    input  logic [2*NUM_REQ-1:0]   num_i,
    input  logic [NUM_REQ-1:0]     lst_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [ID_WD-1:0]       gnt_id_o,
    output logic                   busy_o,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [31:0]            crc_o,
    output logic                   core_start_o,
    output logic                   core_val_o,
    output logic                   core_lst_o,
    output logic [31:0]            core_dat_o,
    output logic [1:0]             core_num_o,
    input  logic                   core_done_i,
    input  logic                   core_val_i,
    input  logic [31:0]            core_dat_i
);

    typedef enum logic [1:0] {IDLE, GNT, RUN} state_t;

    state_t             state_r, state_nxt;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt;
    logic [ID_WD-1:0]   id_r, id_nxt;
    logic [ID_WD-1:0]   last_r, last_nxt;
    logic [ID_WD-1:0]   pick_id;
    logic               pick_vld;
    logic               busy;

    // Round-robin pick: scan offsets 1..NUM_REQ after the last served requester,
    // so the most recently served one has the lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pick_vld && req_i[k] && ((int'(last_r) + i) % NUM_REQ) == k) begin
                    pick_vld = 1'b1;
                    pick_id  = ID_WD'(k);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state_r;
        gnt_nxt   = gnt_r;
        id_nxt    = id_r;
        last_nxt  = last_r;
        case (state_r)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GNT;
                    id_nxt    = pick_id;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        gnt_nxt[k] = (pick_id == ID_WD'(k));
                    end
                end
            end
            GNT: begin
                // start beats a simultaneous req drop
                if (|(start_i & gnt_r)) begin
                    state_nxt = RUN;
                end else if (!(|(req_i & gnt_r))) begin
                    // withdrawal before start does not count as service
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            RUN: begin
                if (core_done_i) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = id_r;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            id_r    <= '0;
            last_r  <= ID_WD'(NUM_REQ - 1);
        end else begin
            state_r <= state_nxt;
            gnt_r   <= gnt_nxt;
            id_r    <= id_nxt;
            last_r  <= last_nxt;
        end
    end

    assign busy = (state_r != IDLE);

    // Data slice selection keyed off the registered grant index
    always_comb begin
        core_dat_o = '0;
        core_num_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (busy && id_r == ID_WD'(k)) begin
                core_dat_o = dat_i[32*k +: 32];
                core_num_o = num_i[2*k +: 2];
            end
        end
    end

    assign core_start_o = |(start_i & gnt_r);
    assign core_val_o   = |(val_i & gnt_r);
    assign core_lst_o   = |(lst_i & gnt_r);

    assign ack_o    = {NUM_REQ{core_val_i}} & gnt_r;
    assign done_o   = {NUM_REQ{core_done_i}} & gnt_r;
    assign crc_o    = core_dat_i;
    assign gnt_o    = gnt_r;
    assign gnt_id_o = id_r;
    assign busy_o   = busy;

endmodule

// File: tb/tb_crc32_arb.sv
// Bench for crc32_arb with a behavioural crc32_core stub (PNG CRC-32, one-cycle done after last beat).
// Latency: stimulus driven 1ns after posedge, outputs sampled 1ns later in the same cycle.
// Backpressure: requesters modelled as holding req until their message completes or they withdraw.
module tb_crc32_arb;

    localparam logic [31:0] IEND     = 32'h49454E44;
    localparam logic [31:0] IEND_CRC = 32'hAE426082;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req, start, val, lst;
    logic [63:0] dat;
    logic [3:0]  num;
    logic [1:0]  gnt_o, gnt_id_o, ack_o, done_o;
    logic        busy_o, core_start_o, core_val_o, core_lst_o;
    logic [31:0] crc_o, core_dat_o;
    logic [1:0]  core_num_o;
    logic        core_done, core_val;
    logic [31:0] core_dat, stub_crc;

    int total = 0;
    int bad   = 0;

    crc32_arb #(.NUM_REQ(2), .ID_WD(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_i(req), .start_i(start), .val_i(val), .dat_i(dat), .num_i(num), .lst_i(lst),
        .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .busy_o(busy_o), .ack_o(ack_o), .done_o(done_o),
        .crc_o(crc_o),
        .core_start_o(core_start_o), .core_val_o(core_val_o), .core_lst_o(core_lst_o),
        .core_dat_o(core_dat_o), .core_num_o(core_num_o),
        .core_done_i(core_done), .core_val_i(core_val), .core_dat_i(core_dat)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] beat_crc(input logic [31:0] c, input logic v,
                                             input logic [31:0] d, input logic [1:0] n);
        logic [31:0] r;
        r = c;
        if (v) for (int b = 0; b < 4; b++) if (b <= int'(n)) r = crc_upd(r, d[31-8*b -: 8]);
        return r;
    endfunction

    // crc32_core stub
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stub_crc  <= 32'hFFFFFFFF;
            core_done <= 1'b0;
            core_val  <= 1'b0;
            core_dat  <= '0;
        end else begin
            stub_crc  <= beat_crc(core_start_o ? 32'hFFFFFFFF : stub_crc, core_val_o, core_dat_o, core_num_o);
            core_done <= core_val_o & core_lst_o;
            core_val  <= core_val_o & core_lst_o;
            if (core_val_o & core_lst_o)
                core_dat <= ~beat_crc(core_start_o ? 32'hFFFFFFFF : stub_crc, 1'b1, core_dat_o, core_num_o);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beat();
        start = '0; val = '0; lst = '0; dat = '0; num = '0;
    endtask

    task automatic reset_dut(input logic [1:0] r);
        rstn = 1'b0;
        clear_beat();
        req = r;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Called during the granted (GNT or RUN) cycle: start, IEND beat, then done check.
    task automatic send_iend(input int k, input string nm);
        start = '0;
        start[k] = 1'b1;
        #1 chk({nm, "_cstart"}, core_start_o, 1);
        step();
        start = '0;
        val[k] = 1'b1;
        lst[k] = 1'b1;
        dat[32*k +: 32] = IEND;
        num[2*k +: 2] = 2'd3;
        #1 chk({nm, "_cdat"}, core_dat_o, IEND);
        step();
        clear_beat();
        #1;
        chk({nm, "_done"}, done_o, 32'd1 << k);
        chk({nm, "_ack"}, ack_o, 32'd1 << k);
        chk({nm, "_crc"}, crc_o, IEND_CRC);
    endtask

    typedef struct {
        logic [1:0]  req, start, val, lst;
        logic [31:0] dat0, dat1;
        logic [3:0]  num;
        logic [1:0]  e_gnt, e_id;
        logic        e_busy, e_cs, e_cv, e_cl;
        logic [31:0] e_cdat;
        logic [1:0]  e_cnum, e_done;
        logic [31:0] e_crc;
    } vec_t;

    vec_t tv[11];

    // Random-phase model state
    int          owner, last_m, beats_left;
    logic        started, sent_last, done_due;
    logic [1:0]  have_msg, exp_g, exp_d;
    logic [7:0]  msg_q[$];

    function automatic int pick(input logic [1:0] r, input int l);
        for (int i = 1; i <= 2; i++) if (r[(l + i) % 2]) return (l + i) % 2;
        return -1;
    endfunction

    function automatic logic [31:0] crc_q();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (msg_q[i]) c = crc_upd(c, msg_q[i]);
        return ~c;
    endfunction

    initial begin
        //          req    start  val    lst    dat0          dat1          num      gnt   id    busy cs  cv  cl  cdat          cnum  done  crc
        tv[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        4'b0000, 2'b00, 2'd0, 0, 0, 0, 0, 32'h0,        2'd0, 2'b00, 32'h0};
        tv[1]  = '{2'b01, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0,        4'b0000, 2'b01, 2'd0, 1, 1, 0, 0, 32'h0,        2'd0, 2'b00, 32'h0};
        tv[2]  = '{2'b01, 2'b10, 2'b11, 2'b01, IEND,         32'hFFFFFFFF, 4'b0011, 2'b01, 2'd0, 1, 0, 1, 1, IEND,         2'd3, 2'b00, 32'h0};
        tv[3]  = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        4'b0000, 2'b01, 2'd0, 1, 0, 0, 0, 32'h0,        2'd0, 2'b01, IEND_CRC};
        tv[4]  = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        4'b0000, 2'b00, 2'd0, 0, 0, 0, 0, 32'h0,        2'd0, 2'b00, IEND_CRC};
        tv[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h12345678, 32'h0,        4'b0000, 2'b01, 2'd0, 1, 0, 0, 0, 32'h12345678, 2'd0, 2'b00, IEND_CRC};
        tv[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h12345678, 32'h0,        4'b0000, 2'b00, 2'd0, 0, 0, 0, 0, 32'h0,        2'd0, 2'b00, IEND_CRC};
        tv[7]  = '{2'b10, 2'b01, 2'b01, 2'b01, 32'hAAAA5555, 32'h0,        4'b1111, 2'b00, 2'd0, 0, 0, 0, 0, 32'h0,        2'd0, 2'b00, IEND_CRC};
        tv[8]  = '{2'b10, 2'b01, 2'b01, 2'b01, 32'hAAAA5555, 32'h0BADF00D, 4'b1001, 2'b10, 2'd1, 1, 0, 0, 0, 32'h0BADF00D, 2'd2, 2'b00, IEND_CRC};
        tv[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        4'b0000, 2'b10, 2'd1, 1, 0, 0, 0, 32'h0,        2'd0, 2'b00, IEND_CRC};
        tv[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        4'b0000, 2'b00, 2'd1, 0, 0, 0, 0, 32'h0,        2'd0, 2'b00, IEND_CRC};

        // Reset state with garbage inputs
        rstn = 1'b0;
        req = 2'b11; start = 2'b11; val = 2'b11; lst = 2'b11; dat = '1; num = '1;
        step();
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_id", gnt_id_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cstart", core_start_o, 0);
        chk("rst_cval", core_val_o, 0);
        chk("rst_clst", core_lst_o, 0);
        chk("rst_cdat", core_dat_o, 0);
        chk("rst_cnum", core_num_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_done", done_o, 0);

        // Single message, masking, gap, idle forwarding
        reset_dut(2'b00);
        for (int i = 0; i < 11; i++) begin
            req = tv[i].req; start = tv[i].start; val = tv[i].val; lst = tv[i].lst;
            dat = {tv[i].dat1, tv[i].dat0}; num = tv[i].num;
            #1;
            chk($sformatf("tv%0d_gnt", i), gnt_o, tv[i].e_gnt);
            chk($sformatf("tv%0d_id", i), gnt_id_o, tv[i].e_id);
            chk($sformatf("tv%0d_busy", i), busy_o, tv[i].e_busy);
            chk($sformatf("tv%0d_cstart", i), core_start_o, tv[i].e_cs);
            chk($sformatf("tv%0d_cval", i), core_val_o, tv[i].e_cv);
            chk($sformatf("tv%0d_clst", i), core_lst_o, tv[i].e_cl);
            chk($sformatf("tv%0d_cdat", i), core_dat_o, tv[i].e_cdat);
            chk($sformatf("tv%0d_cnum", i), core_num_o, tv[i].e_cnum);
            chk($sformatf("tv%0d_done", i), done_o, tv[i].e_done);
            chk($sformatf("tv%0d_crc", i), crc_o, tv[i].e_crc);
            step();
        end

        // Contention: both requesting at reset release
        reset_dut(2'b11);
        #1 chk("cont_idle", gnt_o, 0);
        step();
        #1 chk("cont_g0", gnt_o, 2'b01);
        send_iend(0, "cont_m0");
        step();
        #1 chk("cont_gap", gnt_o, 0);
        step();
        #1 chk("cont_g1", gnt_o, 2'b10);
        chk("cont_id1", gnt_id_o, 1);
        send_iend(1, "cont_m1");
        step();
        #1 chk("cont_gap2", gnt_o, 0);
        step();
        #1 chk("cont_g0b", gnt_o, 2'b01);

        // Early withdrawal keeps the round-robin pointer
        reset_dut(2'b01);
        step();
        #1 chk("wd_g0", gnt_o, 2'b01);
        send_iend(0, "wd_m0");
        step();
        req = 2'b10;
        #1 chk("wd_idle", gnt_o, 0);
        step();
        #1 chk("wd_g1", gnt_o, 2'b10);
        req = 2'b00;
        step();
        req = 2'b11;
        #1 chk("wd_drop", gnt_o, 0);
        chk("wd_drop_busy", busy_o, 0);
        step();
        #1 chk("wd_regrant", gnt_o, 2'b10);

        // Reset mid-RUN
        reset_dut(2'b01);
        step();
        start = 2'b01;
        step();
        start = 2'b00; val = 2'b01; dat[31:0] = IEND; num = 4'b0011;
        step();
        clear_beat();
        #1 chk("mr_busy_pre", busy_o, 1);
        rstn = 1'b0;
        #1;
        chk("mr_gnt", gnt_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_done", done_o, 0);
        step();
        #1 chk("mr_done2", done_o, 0);
        req = 2'b10;
        rstn = 1'b1;
        #1 chk("mr_idle", gnt_o, 0);
        step();
        #1 chk("mr_g1", gnt_o, 2'b10);
        chk("mr_id1", gnt_id_o, 1);

        // Restart inside RUN discards the partial beat
        reset_dut(2'b01);
        step();
        start = 2'b01;
        step();
        start = 2'b00; val = 2'b01; dat[31:0] = 32'h12345678; num = 4'b0001;
        step();
        clear_beat();
        #1 chk("rs_busy", busy_o, 1);
        send_iend(0, "rs_m0");
        step();
        #1 chk("rs_after", gnt_o, 0);

        // Randomised traffic against a transaction-level model
        reset_dut(2'b00);
        owner = -1; last_m = 1; have_msg = '0;
        started = 0; sent_last = 0; done_due = 0; beats_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < 2; k++)
                if (!have_msg[k] && k != owner && $urandom % 4 == 0) have_msg[k] = 1'b1;
            start = '0; val = '0; lst = '0;
            dat = {$urandom, $urandom};
            num = 4'($urandom);
            for (int k = 0; k < 2; k++) begin
                if (k != owner) begin
                    start[k] = ($urandom % 4 == 0);
                    val[k]   = ($urandom % 3 == 0);
                    lst[k]   = 1'($urandom);
                end
            end
            if (owner >= 0) begin
                if (!started) begin
                    if ($urandom % 8 == 0) have_msg[owner] = 1'b0;
                    else if ($urandom % 4 != 0) start[owner] = 1'b1;
                end else if (!sent_last && $urandom % 2 == 0) begin
                    val[owner] = 1'b1;
                    if (beats_left == 0) begin
                        lst[owner] = 1'b1;
                        sent_last = 1'b1;
                    end else begin
                        beats_left--;
                    end
                end
            end
            req = have_msg;
            #1;
            exp_g = (owner >= 0) ? 2'(1 << owner) : 2'b00;
            exp_d = done_due ? exp_g : 2'b00;
            chk("rnd_gnt", gnt_o, exp_g);
            chk("rnd_done", done_o, exp_d);
            chk("rnd_ack", ack_o, exp_d);
            chk("rnd_cstart", core_start_o, (owner >= 0) ? start[owner] : 1'b0);
            if (done_due) chk("rnd_crc", crc_o, crc_q());
            if (owner < 0) begin
                if (|req) begin
                    owner = pick(req, last_m);
                    started = 0; sent_last = 0; done_due = 0;
                    beats_left = $urandom_range(0, 3);
                end
            end else if (!started) begin
                if (start[owner]) begin
                    started = 1'b1;
                    msg_q.delete();
                end else if (!req[owner]) begin
                    owner = -1;
                end
            end else if (done_due) begin
                last_m = owner;
                have_msg[owner] = 1'b0;
                owner = -1;
                done_due = 1'b0;
            end else if (val[owner]) begin
                for (int b = 0; b <= int'(num[2*owner +: 2]); b++)
                    msg_q.push_back(dat[32*owner + 31 - 8*b -: 8]);
                if (lst[owner]) done_due = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
